// File: rtl/dsm_pkg.sv
// Shared definitions for the second-generation delta-sigma DAC.
//   fs_val()    : full-scale feedback magnitude, 2^(BW-1)
//   i1_width()  : first integrator width, BW+2
//   i2_width()  : second integrator width, BW+4
//   sum_width() : moving-average running-sum width, BW+TAPS_LOG2
//   sat()       : clamp a 32-bit signed value into a W-bit signed range
//   sat_hit()   : high when sat() would clamp
package dsm_pkg;

   localparam int ACC_W = 32;  // width of the unsaturated integrator arithmetic

   function automatic int fs_val(input int bw);
      return 1 << (bw - 1);
   endfunction

   function automatic int i1_width(input int bw);
      return bw + 2;
   endfunction

   function automatic int i2_width(input int bw);
      return bw + 4;
   endfunction

   function automatic int sum_width(input int bw, input int taps_log2);
      return bw + taps_log2;
   endfunction

   function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] v,
                                                    input int w);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

   function automatic logic sat_hit(input logic signed [ACC_W-1:0] v, input int w);
      return sat(v, w) != v;
   endfunction

endpackage

// File: rtl/dsm_dac_gen2_ma_filter.sv
// Moving-average interpolation filter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of taps and running sum
//   push_i        : shift din_i in this cycle
//   din_i         : signed sample
//   avg_o         : running sum >>> TAPS_LOG2 (combinational from registers)
module ma_filter
   import dsm_pkg::*;
#(
   parameter int BW        = 14,
   parameter int TAPS_LOG2 = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [BW-1:0] din_i,
   output logic [BW-1:0] avg_o
);

   localparam int NT = 1 << TAPS_LOG2;
   localparam int SW = sum_width(BW, TAPS_LOG2);

   logic [BW-1:0]        taps_q [NT];
   logic signed [SW-1:0] sum_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NT; k++) taps_q[k] <= '0;
         sum_q <= '0;
      end else if (clr_i) begin
         for (int k = 0; k < NT; k++) taps_q[k] <= '0;
         sum_q <= '0;
      end else if (push_i) begin
         taps_q[0] <= din_i;
         for (int k = 1; k < NT; k++) taps_q[k] <= taps_q[k-1];
         // Running sum: add the newcomer, drop the sample falling off the end.
         sum_q <= sum_q + SW'($signed(din_i)) - SW'($signed(taps_q[NT-1]));
      end
   end

   // The mean of NT BW-bit values always fits back into BW bits.
   assign avg_o = BW'(sum_q >>> TAPS_LOG2);

endmodule

// File: rtl/dsm_dac_gen2.sv
// Oversampled delta-sigma DAC: moving-average interpolator feeding a
// run-time selectable 1st/2nd-order modulator with saturating integrators.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : run enable; low clears all state and latches order2_i
//   order2_i      : 0 = 1st order, 1 = 2nd order (sampled only while idle)
//   din_i         : signed input sample, din_valid_i / din_ready_o handshake
//   dac_o         : 1-bit modulator output
//   ovf_o         : one-cycle pulse when an integrator clamped
//   underrun_o    : one-cycle pulse when a frame slot found no valid sample
// Handshake: a sample transfers on the rising edge where din_ready_o and
// din_valid_i are both high; ready never waits on valid, and valid is not
// required to hold once a transfer has occurred.
module dsm_dac_gen2
   import dsm_pkg::*;
#(
   parameter int BW        = 14,
   parameter int TAPS_LOG2 = 3,
   parameter int OSR_LOG2  = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          order2_i,
   input  logic [BW-1:0] din_i,
   input  logic          din_valid_i,
   output logic          din_ready_o,
   output logic          dac_o,
   output logic          ovf_o,
   output logic          underrun_o
);

   localparam int I1W = i1_width(BW);
   localparam int I2W = i2_width(BW);
   localparam logic signed [ACC_W-1:0] FS = ACC_W'(fs_val(BW));

   logic [OSR_LOG2-1:0]     osr_cnt_q;
   logic                    order_q;
   logic [BW-1:0]           last_q;
   logic signed [BW-1:0]    x_q;
   logic signed [I1W-1:0]   i1_q;
   logic signed [I2W-1:0]   i2_q;
   logic                    dac_q;
   logic                    ovf_q;
   logic                    und_q;

   logic                    slot;
   logic [BW-1:0]           push_data;
   logic [BW-1:0]           avg;
   logic signed [ACC_W-1:0] fb;
   logic signed [ACC_W-1:0] i1_raw, i1_nx;
   logic signed [ACC_W-1:0] i2_raw, i2_nx;
   logic                    ovf1, ovf2;
   logic                    dac_nx;

   // rst_ni is folded in so ready is low throughout reset even with en_i high.
   assign slot        = rst_ni & en_i & (osr_cnt_q == '0);
   assign din_ready_o = slot;
   // A missing sample repeats the previous one rather than injecting zero.
   assign push_data   = din_valid_i ? din_i : last_q;

   ma_filter #(
      .BW        (BW),
      .TAPS_LOG2 (TAPS_LOG2)
   ) u_filter (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (~en_i),
      .push_i (slot),
      .din_i  (push_data),
      .avg_o  (avg)
   );

   always_comb begin
      fb     = dac_q ? FS : -FS;
      i1_raw = ACC_W'(i1_q) + ACC_W'(x_q) - fb;
      i1_nx  = sat(i1_raw, I1W);
      ovf1   = sat_hit(i1_raw, I1W);
      i2_raw = ACC_W'(i2_q) + i1_nx - fb;
      i2_nx  = sat(i2_raw, I2W);
      ovf2   = order_q & sat_hit(i2_raw, I2W);
      dac_nx = order_q ? ~i2_nx[ACC_W-1] : ~i1_nx[ACC_W-1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         osr_cnt_q <= '0;
         order_q   <= 1'b0;
         last_q    <= '0;
         x_q       <= '0;
         i1_q      <= '0;
         i2_q      <= '0;
         dac_q     <= 1'b0;
         ovf_q     <= 1'b0;
         und_q     <= 1'b0;
      end else if (!en_i) begin
         osr_cnt_q <= '0;
         order_q   <= order2_i;
         last_q    <= '0;
         x_q       <= '0;
         i1_q      <= '0;
         i2_q      <= '0;
         dac_q     <= 1'b0;
         ovf_q     <= 1'b0;
         und_q     <= 1'b0;
      end else begin
         osr_cnt_q <= osr_cnt_q + 1'b1;
         // Registering the filter mean puts one cycle between a push and the
         // modulator seeing it.
         x_q       <= $signed(avg);
         i1_q      <= I1W'(i1_nx);
         if (order_q) i2_q <= I2W'(i2_nx);
         dac_q     <= dac_nx;
         ovf_q     <= ovf1 | ovf2;
         und_q     <= slot & ~din_valid_i;
         if (slot) last_q <= push_data;
      end
   end

   assign dac_o      = dac_q;
   assign ovf_o      = ovf_q;
   assign underrun_o = und_q;

endmodule
